// File: rtl/frame_pkg.sv
// Shared definitions for the frame generator / checker loopback path:
// control characters, fill byte, error codes and checker state.
package frame_pkg;

   localparam logic [7:0] DEF_IDLE_CODE  = 8'h07;
   localparam logic [7:0] DEF_START_CODE = 8'hFB;
   localparam logic [7:0] DEF_EOF_CODE   = 8'hFD;
   localparam logic [7:0] DEF_DATA_BYTE  = 8'hAA;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_PATTERN = 2'd1,
      ERR_LENGTH  = 2'd2,
      ERR_CTRL    = 2'd3
   } err_code_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } chk_state_t;

   typedef enum logic [2:0] {
      CLS_DATA,
      CLS_START,
      CLS_EOF,
      CLS_IDLE,
      CLS_OTHER
   } word_cls_t;

endpackage

// File: rtl/frame_checker_if.sv
// Receive word stream into the checker and its per-frame report outputs.
interface frame_checker_if #(
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 16,
   parameter int CNT_WIDTH  = 16
);
   logic [DATA_WIDTH-1:0] i_rx_data;
   logic                  i_rx_ctrl;
   logic                  o_in_frame;
   logic                  o_frame_ok;
   logic                  o_frame_err;
   logic [1:0]            o_err_code;
   logic [LEN_WIDTH-1:0]  o_last_len;
   logic [CNT_WIDTH-1:0]  o_frame_cnt;
   logic [CNT_WIDTH-1:0]  o_err_cnt;

   modport master (
      output i_rx_data, i_rx_ctrl,
      input  o_in_frame, o_frame_ok, o_frame_err, o_err_code,
             o_last_len, o_frame_cnt, o_err_cnt
   );

   modport slave (
      input  i_rx_data, i_rx_ctrl,
      output o_in_frame, o_frame_ok, o_frame_err, o_err_code,
             o_last_len, o_frame_cnt, o_err_cnt
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o
);
   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != {WIDTH{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/frame_checker.sv
// Delineates START/data/EOF frames, checks fill pattern and length, and
// reports one registered pass/fail pulse per closed or aborted frame.
module frame_checker
   import frame_pkg::*;
#(
   parameter int         DATA_WIDTH  = 64,
   parameter int         DATA_LENGTH = 64,
   parameter logic [7:0] IDLE_CODE   = DEF_IDLE_CODE,
   parameter logic [7:0] START_CODE  = DEF_START_CODE,
   parameter logic [7:0] EOF_CODE    = DEF_EOF_CODE,
   parameter logic [7:0] DATA_BYTE   = DEF_DATA_BYTE,
   parameter int         CNT_WIDTH   = 16,
   parameter int         LEN_WIDTH   = 16
) (
   input  logic            clk,
   input  logic            i_rst,
   frame_checker_if.slave  bus
);
   localparam logic [DATA_WIDTH-1:0] FILL_WORD = {(DATA_WIDTH/8){DATA_BYTE}};
   localparam logic [LEN_WIDTH-1:0]  EXP_LEN   = LEN_WIDTH'(DATA_LENGTH);

   chk_state_t           state_q, state_d;
   word_cls_t            cls;
   logic                 ok_q, ok_d;
   logic                 err_q, err_d;
   err_code_t            code_q, code_d;
   logic [LEN_WIDTH-1:0] last_len_q, last_len_d;
   logic                 pat_q, pat_d;
   logic                 len_inc, len_clr;
   logic [LEN_WIDTH-1:0] len_cnt;

   // Only byte 0 identifies a control word; upper bytes are ignored.
   always_comb begin
      cls = CLS_OTHER;
      if (!bus.i_rx_ctrl)                      cls = CLS_DATA;
      else if (bus.i_rx_data[7:0] == START_CODE) cls = CLS_START;
      else if (bus.i_rx_data[7:0] == EOF_CODE)   cls = CLS_EOF;
      else if (bus.i_rx_data[7:0] == IDLE_CODE)  cls = CLS_IDLE;
   end

   always_comb begin
      state_d    = state_q;
      ok_d       = 1'b0;
      err_d      = 1'b0;
      code_d     = code_q;
      last_len_d = last_len_q;
      pat_d      = pat_q;
      len_inc    = 1'b0;
      len_clr    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cls == CLS_START) begin
               state_d = ST_DATA;
               len_clr = 1'b1;
               pat_d   = 1'b0;
            end
         end
         ST_DATA: begin
            case (cls)
               CLS_DATA: begin
                  len_inc = 1'b1;
                  if (bus.i_rx_data != FILL_WORD) pat_d = 1'b1;
               end
               CLS_EOF: begin
                  state_d    = ST_IDLE;
                  last_len_d = len_cnt;
                  if (pat_q) begin
                     err_d  = 1'b1;
                     code_d = ERR_PATTERN;
                  end else if (len_cnt != EXP_LEN) begin
                     err_d  = 1'b1;
                     code_d = ERR_LENGTH;
                  end else begin
                     ok_d   = 1'b1;
                     code_d = ERR_NONE;
                  end
               end
               // Report the aborted frame with the old length, then reopen.
               CLS_START: begin
                  err_d      = 1'b1;
                  code_d     = ERR_CTRL;
                  last_len_d = len_cnt;
                  len_clr    = 1'b1;
                  pat_d      = 1'b0;
               end
               default: begin
                  state_d    = ST_IDLE;
                  err_d      = 1'b1;
                  code_d     = ERR_CTRL;
                  last_len_d = len_cnt;
               end
            endcase
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= ERR_NONE;
         last_len_q <= '0;
         pat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ok_q       <= ok_d;
         err_q      <= err_d;
         code_q     <= code_d;
         last_len_q <= last_len_d;
         pat_q      <= pat_d;
      end
   end

   sat_counter #(.WIDTH(LEN_WIDTH)) u_len_cnt (
      .clk   (clk),
      .i_rst (i_rst),
      .inc_i (len_inc),
      .clr_i (len_clr),
      .cnt_o (len_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
      .clk   (clk),
      .i_rst (i_rst),
      .inc_i (ok_d),
      .clr_i (1'b0),
      .cnt_o (bus.o_frame_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
      .clk   (clk),
      .i_rst (i_rst),
      .inc_i (err_d),
      .clr_i (1'b0),
      .cnt_o (bus.o_err_cnt)
   );

   assign bus.o_in_frame  = (state_q == ST_DATA);
   assign bus.o_frame_ok  = ok_q;
   assign bus.o_frame_err = err_q;
   assign bus.o_err_code  = code_q;
   assign bus.o_last_len  = last_len_q;
endmodule

// File: tb/tb_frame_checker.sv
// Directed stimulus with a report scoreboard for frame_checker; a second
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_frame_checker;
   localparam logic [63:0] GOOD  = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [63:0] BAD   = 64'hAAAA_AAAA_AAAA_AA00;
   localparam logic [63:0] START = 64'h0707_0707_0707_07FB;
   localparam logic [63:0] EOFW  = 64'h0707_0707_0707_07FD;
   localparam logic [63:0] IDLEW = 64'h0707_0707_0707_0707;

   typedef struct {
      logic        ok;
      logic [1:0]  code;
      logic [15:0] len;
      logic [15:0] fcnt;
      logic [15:0] ecnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] d   = '0;
   logic        c   = 1'b0;
   int          n_vec  = 0;
   int          n_fail = 0;
   logic [15:0] exp_fcnt = '0;
   logic [15:0] exp_ecnt = '0;
   exp_t        sb[$];

   frame_checker_if #(.DATA_WIDTH(64), .LEN_WIDTH(16), .CNT_WIDTH(16)) u_if ();
   frame_checker_if #(.DATA_WIDTH(64), .LEN_WIDTH(16), .CNT_WIDTH(2))  u_if_s ();

   assign u_if.i_rx_data   = d;
   assign u_if.i_rx_ctrl   = c;
   assign u_if_s.i_rx_data = d;
   assign u_if_s.i_rx_ctrl = c;

   frame_checker #(.CNT_WIDTH(16)) dut (.clk(clk), .i_rst(rst), .bus(u_if.slave));
   frame_checker #(.CNT_WIDTH(2))  dut_s (.clk(clk), .i_rst(rst), .bus(u_if_s.slave));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic send(input logic ctrl, input logic [63:0] w);
      c = ctrl;
      d = w;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(1'b1, IDLEW);
   endtask

   task automatic push_ok(input int len);
      exp_t e;
      if (exp_fcnt != 16'hFFFF) exp_fcnt++;
      e.ok = 1'b1; e.code = 2'd0; e.len = 16'(len); e.fcnt = exp_fcnt; e.ecnt = exp_ecnt;
      sb.push_back(e);
   endtask

   task automatic push_err(input logic [1:0] code, input int len);
      exp_t e;
      if (exp_ecnt != 16'hFFFF) exp_ecnt++;
      e.ok = 1'b0; e.code = code; e.len = 16'(len); e.fcnt = exp_fcnt; e.ecnt = exp_ecnt;
      sb.push_back(e);
   endtask

   // START, n data words (one optionally corrupted), EOF, then idles.
   task automatic frame(input int n, input int bad_idx, input int idles);
      send(1'b1, START);
      for (int i = 0; i < n; i++) send(1'b0, (i == bad_idx) ? BAD : GOOD);
      send(1'b1, EOFW);
      idle(idles);
   endtask

   // Monitor: every report pulse must match the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && (u_if.o_frame_ok || u_if.o_frame_err)) begin
            if (sb.size() == 0) begin
               chk("unexpected_report", {62'd0, u_if.o_frame_ok, u_if.o_frame_err}, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rep_ok",   64'(u_if.o_frame_ok),  64'(e.ok));
               chk("rep_err",  64'(u_if.o_frame_err), 64'(!e.ok));
               chk("rep_code", 64'(u_if.o_err_code),  64'(e.code));
               chk("rep_len",  64'(u_if.o_last_len),  64'(e.len));
               chk("rep_fcnt", 64'(u_if.o_frame_cnt), 64'(e.fcnt));
               chk("rep_ecnt", 64'(u_if.o_err_cnt),   64'(e.ecnt));
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_frame", 64'(u_if.o_in_frame),  64'd0);
      chk("rst_ok",       64'(u_if.o_frame_ok),  64'd0);
      chk("rst_err",      64'(u_if.o_frame_err), 64'd0);
      chk("rst_code",     64'(u_if.o_err_code),  64'd0);
      chk("rst_len",      64'(u_if.o_last_len),  64'd0);
      chk("rst_fcnt",     64'(u_if.o_frame_cnt), 64'd0);
      chk("rst_ecnt",     64'(u_if.o_err_cnt),   64'd0);
      rst = 1'b0;

      // Stray words outside any frame must stay silent.
      send(1'b0, 64'd0);
      send(1'b0, GOOD);
      send(1'b1, EOFW);
      send(1'b0, BAD);
      idle(2);
      chk("idle_no_frame", 64'(u_if.o_in_frame), 64'd0);

      for (int f = 0; f < 10; f++) begin
         push_ok(64);
         frame(64, -1, 16);
      end
      chk("ten_fcnt", 64'(u_if.o_frame_cnt), 64'd10);
      chk("ten_ecnt", 64'(u_if.o_err_cnt),   64'd0);
      chk("ten_len",  64'(u_if.o_last_len),  64'd64);

      push_err(2'd1, 64); frame(64, 5, 4);
      push_err(2'd2, 63); frame(63, -1, 4);
      push_err(2'd2, 65); frame(65, -1, 4);

      // START-abort: in_frame must stay high through the restart.
      push_err(2'd3, 10);
      push_ok(64);
      send(1'b1, START);
      for (int i = 0; i < 10; i++) send(1'b0, GOOD);
      send(1'b1, START);
      chk("restart_in_frame", 64'(u_if.o_in_frame), 64'd1);
      for (int i = 0; i < 64; i++) send(1'b0, GOOD);
      chk("restart_in_frame2", 64'(u_if.o_in_frame), 64'd1);
      send(1'b1, EOFW);
      chk("eof_in_frame", 64'(u_if.o_in_frame), 64'd0);
      idle(3);

      // Idle control word aborts; the later EOF is outside a frame.
      push_err(2'd3, 20);
      send(1'b1, START);
      for (int i = 0; i < 20; i++) send(1'b0, GOOD);
      send(1'b1, IDLEW);
      chk("abort_in_frame", 64'(u_if.o_in_frame), 64'd0);
      send(1'b1, EOFW);
      idle(3);

      // Control abort outranks a pending pattern error.
      push_err(2'd3, 8);
      send(1'b1, START);
      for (int i = 0; i < 8; i++) send(1'b0, (i == 2) ? BAD : GOOD);
      send(1'b1, 64'h0000_0000_0000_00FB);
      push_ok(64);
      for (int i = 0; i < 64; i++) send(1'b0, GOOD);
      send(1'b1, EOFW);

      // Back-to-back frames: EOF immediately followed by START.
      push_ok(64); frame(64, -1, 0);
      push_ok(64); frame(64, -1, 3);
      chk("s_ecnt_sat", 64'(u_if_s.o_err_cnt), 64'd3);
      chk("q_empty_pre_rst", 64'(sb.size()), 64'd0);

      // Reset mid-frame: outputs clear at once, open frame discarded.
      send(1'b1, START);
      for (int i = 0; i < 5; i++) send(1'b0, GOOD);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_frame", 64'(u_if.o_in_frame),  64'd0);
      chk("mid_rst_code",     64'(u_if.o_err_code),  64'd0);
      chk("mid_rst_len",      64'(u_if.o_last_len),  64'd0);
      chk("mid_rst_fcnt",     64'(u_if.o_frame_cnt), 64'd0);
      chk("mid_rst_ecnt",     64'(u_if.o_err_cnt),   64'd0);
      exp_fcnt = '0;
      exp_ecnt = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(1'b0, GOOD);
      send(1'b1, EOFW);
      idle(2);

      for (int f = 0; f < 5; f++) begin
         push_ok(64);
         frame(64, -1, 2);
      end
      chk("final_fcnt",   64'(u_if.o_frame_cnt),   64'd5);
      chk("s_fcnt_sat",   64'(u_if_s.o_frame_cnt), 64'd3);
      chk("s_ecnt_clear", 64'(u_if_s.o_err_cnt),   64'd0);
      idle(4);
      chk("q_empty_end", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/frame_checker.md
# frame_checker

Receive-side checker that consumes the 64-bit data / 1-bit control word stream produced by the frame generator, one word per clock. It delineates frames (START word → data words → EOF word) and checks each data word against the fixed fill pattern and the frame length against the expected length. It reports a per-frame pass/fail pulse with an error code, and keeps saturating frame and error counters. It sits directly downstream of the generator in the loopback test path.

## Interface
- DATA_WIDTH, 64, word width in bits; multiple of 8.
- DATA_LENGTH, 64, expected number of data words per frame.
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start-of-frame control character.
- EOF_CODE, 8'hFD, end-of-frame control character.
- DATA_BYTE, 8'hAA, fill byte; the expected data word is this byte replicated DATA_WIDTH/8 times.
- CNT_WIDTH, 16, width of the frame and error counters.
- LEN_WIDTH, 16, width of the length counter and of o_last_len.

Ports:
- clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_data  in  DATA_WIDTH  received word; byte 0 is bits [7:0].
- i_rx_ctrl  in  1  1 = control word, 0 = data word.
- o_in_frame  out  1  high while a frame is open (state DATA).
- o_frame_ok  out  1  one-cycle pulse: a frame closed with no error.
- o_frame_err  out  1  one-cycle pulse: a frame closed or aborted with an error.
- o_err_code  out  2  valid with o_frame_err: 0 = none, 1 = pattern, 2 = length, 3 = control abort.
- o_last_len  out  LEN_WIDTH  data-word count of the last closed or aborted frame.
- o_frame_cnt  out  CNT_WIDTH  saturating count of o_frame_ok pulses.
- o_err_cnt  out  CNT_WIDTH  saturating count of o_frame_err pulses.

## Operation
- Word classification, evaluated every cycle:
  - START: ctrl = 1 and byte 0 = START_CODE.
  - EOF: ctrl = 1 and byte 0 = EOF_CODE.
  - OTHER_CTRL: ctrl = 1 and byte 0 matches neither code.
  - DATA: ctrl = 0.
- Only byte 0 is examined for control words; the upper bytes are don't-care.
- FSM has two states, IDLE and DATA.
- IDLE:
  - START → go to DATA, clear the length counter and the pattern-error flag.
  - Any other word → stay in IDLE, no report. Data words outside a frame (including the all-zero word right after generator reset) are ignored silently.
- DATA, per input class:
  - DATA word: length counter increments, saturating at all-ones. If the word ≠ {DATA_WIDTH/8{DATA_BYTE}}, set the sticky pattern-error flag.
  - EOF: close the frame and go to IDLE.
    - Pattern flag set → err_code 1.
    - Otherwise length ≠ DATA_LENGTH → err_code 2.
    - Otherwise → ok.
  - START: abort the current frame with err_code 3, then immediately open a new frame: stay in DATA, clear the length counter and the pattern flag.
  - OTHER_CTRL (including idle): abort with err_code 3 and go to IDLE.
- Error priority: 3 > 1 > 2. Only one code is reported per frame.
- On every close or abort, o_last_len takes the length counter value that includes all data words accepted before the terminating word.
- Counters saturate at 2^CNT_WIDTH − 1 and never wrap.

## Timing
- All outputs are registered.
- A terminating word (EOF or abort) sampled on edge N produces o_frame_ok or o_frame_err, o_err_code and o_last_len after edge N. The pulse lasts exactly one cycle.
- o_frame_cnt and o_err_cnt update on the same edge as their pulse.
- o_in_frame rises after the edge that samples START and falls after the edge that samples EOF or OTHER_CTRL. It stays high across a START-abort.
- o_err_code and o_last_len hold their values until the next report.
- Back-to-back frames with zero idle words between EOF and START are supported.
- Reset values: state IDLE, o_in_frame 0, o_frame_ok 0, o_frame_err 0, o_err_code 0, o_last_len 0, o_frame_cnt 0, o_err_cnt 0, internal length counter 0, pattern flag 0.
- Reset asserted mid-frame discards the open frame with no report.

## Structure
- Shared package frame_pkg holds:
  - IDLE_CODE, START_CODE, EOF_CODE and DATA_BYTE defaults, shared with the generator.
  - The err_code_t enum (ERR_NONE, ERR_PATTERN, ERR_LENGTH, ERR_CTRL).
  - The checker state enum.
- One sub-module, sat_counter (parameter width; inputs inc and clr), is instantiated for the length, frame and error counters.

## Test plan
- Generator defaults (16 idle words, 64 data words) run for 10 frames → 10 o_frame_ok pulses, o_frame_cnt = 10, o_err_cnt = 0, o_last_len = 64.
- Data word 5 replaced by 64'hAAAA_AAAA_AAAA_AA00 → o_frame_err with o_err_code = 1, o_last_len = 64.
- Frame with 63 data words then EOF → o_err_code = 2, o_last_len = 63. With 65 data words → o_err_code = 2, o_last_len = 65.
- START, 10 data words, then START, then 64 data words and EOF → err pulse with code 3 and o_last_len = 10, followed by an ok pulse with o_last_len = 64. o_in_frame stays high throughout.
- After 20 data words, an idle word with ctrl = 1 → err code 3, o_in_frame drops. A following EOF produces no report.
- Reset asserted mid-frame → all outputs 0 the same cycle. Data words with ctrl = 0 before any START produce no pulse. With CNT_WIDTH = 2, 5 good frames → o_frame_cnt = 3 (saturated).
